// File: rtl/stack_pkg.sv
// Shared types and sizing for the RAM8-backed LIFO controller.
// Holds the request opcodes, the FSM state encoding and the default data/address widths.
package stack_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 8;

    typedef enum logic [1:0] {
        OP_PUSH = 2'b00,
        OP_POP  = 2'b01,
        OP_PEEK = 2'b10,
        OP_CLR  = 2'b11
    } stack_op_e;

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD,
        RSP
    } stack_state_e;

endpackage

// File: rtl/ram8.sv
// 8-entry RAM bank: synchronous write when ld is high, combinational read of addr.
// No reset; the contents are undefined until written.
module ram8 #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic              ld,
    input  logic [DATA_W-1:0] in,
    output logic [DATA_W-1:0] out
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (ld) mem[addr] <= in;
    end

    assign out = mem[addr];

endmodule

// File: rtl/ram8_stack_ctrl.sv
// LIFO controller driving RAM8: push/pop/peek/clear requests become RAM write/read cycles.
// Latency: push 2 cycles to ready; pop/peek response at N+2 (underflow at N+1). Optional hwm via STACK_WATERMARK_EN.
// Backpressure: req_ready is high only in IDLE, so exactly one request is in flight at a time.
module ram8_stack_ctrl #(
    parameter int DATA_W = stack_pkg::DATA_W,
    parameter int ADDR_W = stack_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [1:0]        req_op,
    input  logic [DATA_W-1:0] req_data,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_ld,
    output logic [DATA_W-1:0] ram_in,
    input  logic [DATA_W-1:0] ram_out,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              ovf,
    output logic              udf
`ifdef STACK_WATERMARK_EN
    ,
    output logic [ADDR_W:0]   hwm
`endif
);

    import stack_pkg::*;

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(1 << ADDR_W);

    stack_state_e      state_q, state_d;
    stack_op_e         op_q, op_in;
    logic [DATA_W-1:0] data_q;
    logic              err_q;
    logic              accept;

    assign op_in  = stack_op_e'(req_op);
    assign accept = req_valid && req_ready;
    assign full   = (count == FULL_CNT);
    assign empty  = (count == '0);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (op_in)
                        OP_PUSH:         state_d = full  ? IDLE : WR;
                        OP_POP, OP_PEEK: state_d = empty ? RSP  : RD;
                        default:         state_d = IDLE;
                    endcase
                end
            end
            WR:      state_d = IDLE;
            RD:      state_d = RSP;
            RSP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outside a write the address parks on the top entry, (count-1) mod 8.
    always_comb begin
        req_ready = (state_q == IDLE);
        ram_ld    = (state_q == WR) && !rst;
        ram_in    = data_q;
        ram_addr  = (state_q == WR) ? count[ADDR_W-1:0]
                                    : count[ADDR_W-1:0] - ADDR_W'(1);
        rsp_valid = (state_q == RSP);
        rsp_err   = (state_q == RSP) && err_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= OP_PUSH;
            data_q   <= '0;
            err_q    <= 1'b0;
            count    <= '0;
            ovf      <= 1'b0;
            udf      <= 1'b0;
            rsp_data <= '0;
`ifdef STACK_WATERMARK_EN
            hwm      <= '0;
`endif
        end else begin
            if (accept) begin
                op_q   <= op_in;
                data_q <= req_data;
                case (op_in)
                    OP_PUSH: begin
                        if (full) ovf <= 1'b1;
                    end
                    OP_POP, OP_PEEK: begin
                        err_q <= empty;
                        if (empty) begin
                            udf      <= 1'b1;
                            rsp_data <= '0;
                        end
                    end
                    default: begin
                        count <= '0;
                        ovf   <= 1'b0;
                        udf   <= 1'b0;
`ifdef STACK_WATERMARK_EN
                        hwm   <= '0;
`endif
                    end
                endcase
            end
            case (state_q)
                WR: begin
                    count <= count + 1'b1;
`ifdef STACK_WATERMARK_EN
                    if ((count + 1'b1) > hwm) hwm <= count + 1'b1;
`endif
                end
                RD: begin
                    rsp_data <= ram_out;
                    if (op_q == OP_POP) count <= count - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram8_stack_ctrl.sv
// Directed bench for ram8_stack_ctrl wired to a real RAM8 bank.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_ram8_stack_ctrl;

    localparam int DW = 16;
    localparam int AW = 3;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic [1:0]    req_op;
    logic [DW-1:0] req_data;
    logic          req_ready;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic [AW-1:0] ram_addr;
    logic          ram_ld;
    logic [DW-1:0] ram_in;
    logic [DW-1:0] ram_out;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          ovf;
    logic          udf;
`ifdef STACK_WATERMARK_EN
    logic [AW:0]   hwm;
`endif

    int nvec = 0;
    int nerr = 0;

    ram8_stack_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_op(req_op), .req_data(req_data), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .ram_addr(ram_addr), .ram_ld(ram_ld), .ram_in(ram_in), .ram_out(ram_out),
        .count(count), .full(full), .empty(empty), .ovf(ovf), .udf(udf)
`ifdef STACK_WATERMARK_EN
        , .hwm(hwm)
`endif
    );

    ram8 #(.DATA_W(DW), .ADDR_W(AW)) u_ram (
        .clk(clk), .addr(ram_addr), .ld(ram_ld), .in(ram_in), .out(ram_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Present one request at a falling edge; returns at the falling edge after the accepting edge.
    task automatic req(input logic [1:0] op, input logic [DW-1:0] d);
        req_valid = 1'b1;
        req_op    = op;
        req_data  = d;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        nvec++; if (req_ready !== 1'b1) begin nerr++; $display("FAIL reset_ready got %b exp 1", req_ready); end
        nvec++; if (count !== 4'd0) begin nerr++; $display("FAIL reset_count got %0d exp 0", count); end
        nvec++; if ({empty, full, ovf, udf} !== 4'b1000) begin nerr++; $display("FAIL reset_flags got %b exp 1000", {empty, full, ovf, udf}); end
        nvec++; if ({rsp_valid, rsp_err, ram_ld} !== 3'b000) begin nerr++; $display("FAIL reset_pulses got %b exp 000", {rsp_valid, rsp_err, ram_ld}); end
        nvec++; if (rsp_data !== 16'h0000) begin nerr++; $display("FAIL reset_rsp_data got %h exp 0000", rsp_data); end
    endtask

    task automatic test_push_pop();
        logic [DW-1:0] vals [3];
        vals[0] = 16'h1111; vals[1] = 16'h2222; vals[2] = 16'h3333;
        for (int i = 0; i < 3; i++) begin
            nvec++; if (req_ready !== 1'b1) begin nerr++; $display("FAIL push%0d_ready got %b exp 1", i, req_ready); end
            req(2'b00, vals[i]);
            nvec++; if ({ram_ld, ram_addr, ram_in} !== {1'b1, 3'(i), vals[i]}) begin nerr++; $display("FAIL push%0d_wr got ld=%b addr=%0d in=%h exp ld=1 addr=%0d in=%h", i, ram_ld, ram_addr, ram_in, i, vals[i]); end
            nvec++; if (req_ready !== 1'b0) begin nerr++; $display("FAIL push%0d_busy got %b exp 0", i, req_ready); end
            @(negedge clk);
        end
        nvec++; if (count !== 4'd3) begin nerr++; $display("FAIL push3_count got %0d exp 3", count); end
        for (int i = 2; i >= 0; i--) begin
            req(2'b01, 16'h0);
            nvec++; if (rsp_valid !== 1'b0) begin nerr++; $display("FAIL pop%0d_early got %b exp 0", i, rsp_valid); end
            @(negedge clk);
            nvec++; if ({rsp_valid, rsp_err, rsp_data} !== {2'b10, vals[i]}) begin nerr++; $display("FAIL pop%0d_rsp got v=%b e=%b d=%h exp v=1 e=0 d=%h", i, rsp_valid, rsp_err, rsp_data, vals[i]); end
            @(negedge clk);
            nvec++; if ({rsp_valid, req_ready} !== 2'b01) begin nerr++; $display("FAIL pop%0d_after got v=%b rdy=%b exp v=0 rdy=1", i, rsp_valid, req_ready); end
        end
        nvec++; if ({empty, count} !== {1'b1, 4'd0}) begin nerr++; $display("FAIL pop3_empty got e=%b c=%0d exp e=1 c=0", empty, count); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 8; i++) begin
            req(2'b00, 16'hA000 + 16'(i));
            nvec++; if ({ram_ld, ram_addr} !== {1'b1, 3'(i)}) begin nerr++; $display("FAIL fill%0d_wr got ld=%b addr=%0d exp ld=1 addr=%0d", i, ram_ld, ram_addr, i); end
            @(negedge clk);
        end
        nvec++; if ({full, count} !== {1'b1, 4'd8}) begin nerr++; $display("FAIL fill_full got f=%b c=%0d exp f=1 c=8", full, count); end
        req(2'b00, 16'hBEEF);
        nvec++; if ({ram_ld, ovf, req_ready, count} !== {3'b011, 4'd8}) begin nerr++; $display("FAIL ovf_push got ld=%b ovf=%b rdy=%b c=%0d exp ld=0 ovf=1 rdy=1 c=8", ram_ld, ovf, req_ready, count); end
        req(2'b01, 16'h0);
        @(negedge clk);
        nvec++; if ({rsp_valid, rsp_err, rsp_data} !== {2'b10, 16'hA007}) begin nerr++; $display("FAIL ovf_pop got v=%b e=%b d=%h exp v=1 e=0 d=a007", rsp_valid, rsp_err, rsp_data); end
        @(negedge clk);
        nvec++; if ({count, full, ovf} !== {4'd7, 1'b0, 1'b1}) begin nerr++; $display("FAIL ovf_after got c=%0d f=%b ovf=%b exp c=7 f=0 ovf=1", count, full, ovf); end
        req(2'b11, 16'h0);
    endtask

    task automatic test_underflow();
        req(2'b01, 16'h0);
        nvec++; if ({rsp_valid, rsp_err, rsp_data} !== {2'b11, 16'h0000}) begin nerr++; $display("FAIL udf_rsp got v=%b e=%b d=%h exp v=1 e=1 d=0000", rsp_valid, rsp_err, rsp_data); end
        nvec++; if ({udf, count} !== {1'b1, 4'd0}) begin nerr++; $display("FAIL udf_flag got udf=%b c=%0d exp udf=1 c=0", udf, count); end
        @(negedge clk);
        nvec++; if ({rsp_valid, rsp_err, req_ready} !== 3'b001) begin nerr++; $display("FAIL udf_after got v=%b e=%b rdy=%b exp 0 0 1", rsp_valid, rsp_err, req_ready); end
    endtask

    task automatic test_peek_clear();
        req(2'b00, 16'h00FF);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            req(2'b10, 16'h0);
            @(negedge clk);
            nvec++; if ({rsp_valid, rsp_err, rsp_data, count} !== {2'b10, 16'h00FF, 4'd1}) begin nerr++; $display("FAIL peek%0d got v=%b e=%b d=%h c=%0d exp v=1 e=0 d=00ff c=1", i, rsp_valid, rsp_err, rsp_data, count); end
            @(negedge clk);
        end
        req(2'b11, 16'h0);
        nvec++; if ({count, ovf, udf, rsp_valid, empty, req_ready} !== {4'd0, 5'b00011}) begin nerr++; $display("FAIL clear got c=%0d ovf=%b udf=%b v=%b e=%b rdy=%b exp c=0 0 0 0 1 1", count, ovf, udf, rsp_valid, empty, req_ready); end
        @(negedge clk);
        nvec++; if (rsp_valid !== 1'b0) begin nerr++; $display("FAIL clear_norsp got %b exp 0", rsp_valid); end
    endtask

    task automatic test_reset_midflight();
        req(2'b00, 16'h5555);
        rst = 1'b1;
        #1;
        nvec++; if (ram_ld !== 1'b0) begin nerr++; $display("FAIL rstwr_ld got %b exp 0", ram_ld); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        nvec++; if ({count, req_ready} !== {4'd0, 1'b1}) begin nerr++; $display("FAIL rstwr_state got c=%0d rdy=%b exp c=0 rdy=1", count, req_ready); end
        req(2'b01, 16'h0);
        nvec++; if ({rsp_valid, rsp_err} !== 2'b11) begin nerr++; $display("FAIL rstwr_udf got v=%b e=%b exp 1 1", rsp_valid, rsp_err); end
        @(negedge clk);
        req(2'b00, 16'h1234);
        @(negedge clk);
        req(2'b01, 16'h0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        nvec++; if (rsp_valid !== 1'b0) begin nerr++; $display("FAIL rstrd_drop got %b exp 0", rsp_valid); end
        @(negedge clk);
        nvec++; if ({rsp_valid, count, req_ready} !== {1'b0, 4'd0, 1'b1}) begin nerr++; $display("FAIL rstrd_after got v=%b c=%0d rdy=%b exp 0 0 1", rsp_valid, count, req_ready); end
    endtask

`ifdef STACK_WATERMARK_EN
    task automatic test_watermark();
        for (int i = 0; i < 5; i++) begin req(2'b00, 16'(i)); @(negedge clk); end
        for (int i = 0; i < 3; i++) begin req(2'b01, 16'h0); repeat (2) @(negedge clk); end
        req(2'b00, 16'h7777);
        @(negedge clk);
        nvec++; if ({hwm, count} !== {4'd5, 4'd3}) begin nerr++; $display("FAIL hwm_peak got hwm=%0d c=%0d exp hwm=5 c=3", hwm, count); end
        req(2'b11, 16'h0);
        nvec++; if (hwm !== 4'd0) begin nerr++; $display("FAIL hwm_clear got %0d exp 0", hwm); end
    endtask
`endif

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_data  = '0;
        test_reset();
        test_push_pop();
        test_overflow();
        test_underflow();
        test_peek_clear();
        test_reset_midflight();
`ifdef STACK_WATERMARK_EN
        test_watermark();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/ram8_stack_ctrl.md
Name: ram8_stack_ctrl

Overview:
Hardware LIFO controller that sits directly upstream of the 8-entry, 16-bit RAM8 bank. It drives the RAM's addr/ld/in pins and consumes its out bus.
- Turns push/pop/peek/clear requests on a valid/ready interface into RAM write and read cycles.
- Maintains the stack pointer, full/empty flags and sticky error flags.
- Returns popped data on a one-cycle response pulse.

Parameters:
DATA_W, 16, data word width; matches the RAM word.
ADDR_W, 3, RAM address width; DEPTH = 2**ADDR_W = 8.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset; synchronous, active-high
req_valid  in  1  request present
req_op  in  2  00 push, 01 pop, 10 peek, 11 clear
req_data  in  DATA_W  push data
req_ready  out  1  controller can accept a request
rsp_valid  out  1  one-cycle pulse carrying pop/peek result
rsp_data  out  DATA_W  popped/peeked word
rsp_err  out  1  qualifies rsp_valid: underflow, rsp_data = 0
ram_addr  out  ADDR_W  to RAM addr
ram_ld  out  1  to RAM ld
ram_in  out  DATA_W  to RAM in
ram_out  in  DATA_W  from RAM out; combinational read of ram_addr
count  out  ADDR_W+1  occupancy, 0..8
full  out  1  count == 8
empty  out  1  count == 0
ovf  out  1  sticky: push attempted while full
udf  out  1  sticky: pop/peek attempted while empty

Behaviour:
- Reset: state IDLE, count=0, ovf=udf=0, rsp_valid=0, rsp_err=0, rsp_data=0, ram_ld=0, req_ready=1 in the cycle after rst deasserts.
- FSM states: IDLE, WR, RD, RSP.
- req_ready = (state == IDLE). A request is accepted when req_valid && req_ready; req_op and req_data are latched into op_q/data_q on that edge.
- IDLE transitions on accept:
  - push, not full -> WR.
  - push, full -> stay IDLE; ovf<=1; RAM untouched.
  - pop/peek, not empty -> RD.
  - pop/peek, empty -> RSP with rsp_err; udf<=1.
  - clear -> stay IDLE; count<=0, ovf<=0, udf<=0; no response.
- WR (1 cycle): ram_addr=count[ADDR_W-1:0], ram_in=data_q, ram_ld=1; count<=count+1 on exit; -> IDLE.
- RD (1 cycle): ram_addr=count-1; rsp_data<=ram_out on exit; count<=count-1 only for pop; -> RSP.
- RSP (1 cycle): rsp_valid=1; rsp_err=1 only on the underflow path, with rsp_data=0; -> IDLE.
- ram_addr outside WR/RD: (count-1) mod 8, i.e. the top entry. ram_ld=0 in every state except WR.
- Latency:
  - Push accepted at edge N: ram_ld high in cycle N+1, word readable from N+2, req_ready high again at N+2.
  - Pop/peek accepted at N: rsp_valid high in cycle N+2, req_ready high at N+3.
  - Underflow: rsp_valid high at N+1.
- rsp_data holds its last value outside rsp_valid. rsp_err is 0 whenever rsp_valid=0.
- full/empty/count reflect the registered count only; they do not look ahead.
- Wrap: the push that fills the stack writes address 7 (count 7->8); address arithmetic is mod 8, and count itself never wraps.
- rst asserted during WR: ram_ld forced 0 in that cycle (ram_ld = WR && !rst); no RAM write occurs. rst during RD/RSP: response dropped; rsp_valid=0 from the next cycle.
- Sticky flags are cleared only by rst or a clear op.

Optional Feature:
STACK_WATERMARK_EN
- Defined: adds output hwm (ADDR_W+1 bits), the maximum count reached since reset or clear.
  - Updated on WR exit: hwm<=max(hwm, count+1).
  - Reset/clear -> 0.
- Undefined: hwm port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package stack_pkg holds:
  - typedef stack_op_e (OP_PUSH=2'b00, OP_POP=2'b01, OP_PEEK=2'b10, OP_CLR=2'b11);
  - typedef stack_state_e (IDLE, WR, RD, RSP);
  - localparams DATA_W=16, ADDR_W=3, DEPTH=8.
- No sub-module. The controller is a single FSM plus counter.
- The bench instantiates the controller with the existing RAM8 so that ram_out is real.

Test Plan:
- Push 0x1111, 0x2222, 0x3333 back-to-back as ready allows -> count=3; ram_ld pulses at addrs 0,1,2; then pop x3 -> rsp_data 0x3333, 0x2222, 0x1111, rsp_err=0, empty=1.
- 8 pushes 0xA000..0xA007, then a 9th push 0xBEEF -> full=1, ovf=1, count=8, no ram_ld on the 9th; a following pop -> rsp_data=0xA007.
- Pop with count=0 -> rsp_valid one cycle after accept, rsp_err=1, rsp_data=0, udf=1, count stays 0.
- Push 0x00FF, peek twice -> both rsp_data=0x00FF, count stays 1; then clear -> count=0, ovf=udf=0, no rsp_valid.
- Accept push 0x5555, assert rst in the WR cycle -> ram_ld=0 that cycle, count=0 after reset; a subsequent pop underflows (rsp_err=1).
- With STACK_WATERMARK_EN: push 5, pop 3, push 1 -> hwm=5; clear -> hwm=0.
